// File: rtl/mips_pkg.sv
// Shared MIPS fetch-side definitions: address width, PC increment, default vectors,
// the next-PC controller state encoding and the next-state bundle.
package mips_pkg;

   localparam int              ADDR_W           = 32;
   localparam logic [ADDR_W-1:0] PC_INC         = 32'd4;
   localparam logic [ADDR_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] DEF_EXC_VECTOR   = 32'h8000_0180;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      EXC  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              pend_valid;
      logic [ADDR_W-1:0] pend_target;
      logic [ADDR_W-1:0] epc;
      logic              flush;
      logic              misalign;
   } next_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the hazard/branch/exception logic and the next-PC controller.
interface pc_sequencer_if;
   import mips_pkg::*;

   logic              stall;
   logic              imem_ready;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic              exc_req;
   logic [ADDR_W-1:0] exc_pc;
   logic              eret;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              fetch_valid;
   logic              flush;
   logic [ADDR_W-1:0] epc;
   logic              misalign;

   modport master (
      output stall, imem_ready, branch_taken, branch_target, jump, jump_target,
             exc_req, exc_pc, eret,
      input  pc, pc_plus4, fetch_valid, flush, epc, misalign
   );

   modport slave (
      input  stall, imem_ready, branch_taken, branch_target, jump, jump_target,
             exc_req, exc_pc, eret,
      output pc, pc_plus4, fetch_valid, flush, epc, misalign
   );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select: exception, eret, new redirect, pending replay,
// sequential advance, hold. Redirect targets are word-aligned here.
module pc_next_mux
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic              active,
   input  logic              advance,
   input  logic              exc_req,
   input  logic              eret,
   input  logic              jump,
   input  logic              branch_taken,
   input  logic              pend_valid,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] exc_pc,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic [ADDR_W-1:0] epc,
   input  logic [ADDR_W-1:0] pend_target,
   output next_t             nxt
);

   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

   logic [ADDR_W-1:0] raw_target;

   assign raw_target = jump ? jump_target : branch_target;

   always_comb begin
      nxt.pc          = pc;
      nxt.pend_valid  = pend_valid;
      nxt.pend_target = pend_target;
      nxt.epc         = epc;
      nxt.flush       = 1'b0;
      nxt.misalign    = 1'b0;
      if (active) begin
         if (exc_req) begin
            nxt.pc         = EXC_VECTOR;
            nxt.epc        = exc_pc;
            nxt.pend_valid = 1'b0;
            nxt.flush      = 1'b1;
         end else if (eret) begin
            nxt.pc         = epc;
            nxt.pend_valid = 1'b0;
            nxt.flush      = 1'b1;
         end else if ((jump | branch_taken) & ~pend_valid) begin
            nxt.flush    = 1'b1;
            nxt.misalign = |raw_target[1:0];
            if (advance) begin
               nxt.pc = align_word(raw_target);
            end else begin
               nxt.pend_target = align_word(raw_target);
               nxt.pend_valid  = 1'b1;
            end
         end else if (advance) begin
            // A redirect arriving while one is already pending is wrong-path and falls through here.
            if (pend_valid) begin
               nxt.pc         = pend_target;
               nxt.pend_valid = 1'b0;
            end else begin
               nxt.pc = pc_plus4;
            end
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller around the fetch-stage PC register: owns the PC, the pending
// redirect buffer, the saved EPC and the BOOT/RUN/EXC sequencing FSM.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_q, epc_q, pend_target_q, pc_plus4;
   logic              pend_valid_q, flush_q, misalign_q;
   logic              fetch_valid, active, advance;
   next_t             nxt;

   assign pc_plus4 = pc_q + PC_INC;
   assign active   = (state != BOOT);
   assign advance  = (state == RUN) & fetch_valid & bus.imem_ready & ~bus.stall;

   pc_next_mux #(
      .EXC_VECTOR(EXC_VECTOR)
   ) u_mux (
      .active        (active),
      .advance       (advance),
      .exc_req       (bus.exc_req),
      .eret          (bus.eret),
      .jump          (bus.jump),
      .branch_taken  (bus.branch_taken),
      .pend_valid    (pend_valid_q),
      .jump_target   (bus.jump_target),
      .branch_target (bus.branch_target),
      .exc_pc        (bus.exc_pc),
      .pc            (pc_q),
      .pc_plus4      (pc_plus4),
      .epc           (epc_q),
      .pend_target   (pend_target_q),
      .nxt           (nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN,
         EXC:     state_nxt = (bus.exc_req | bus.eret) ? EXC : RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      fetch_valid = (state == RUN);
   end

   // Datapath registers load the mux result; flush/misalign are one-cycle pulses by construction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_VECTOR;
         epc_q         <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         pc_q          <= nxt.pc;
         epc_q         <= nxt.epc;
         pend_valid_q  <= nxt.pend_valid;
         pend_target_q <= nxt.pend_target;
         flush_q       <= nxt.flush;
         misalign_q    <= nxt.misalign;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.fetch_valid = fetch_valid;
   assign bus.flush       = flush_q;
   assign bus.epc         = epc_q;
   assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic, each cycle's
// expected outputs come from a queue-based behavioural model and are checked by a monitor.
module tb_pc_sequencer;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] EXV = 32'h8000_0180;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_sequencer_if intf ();

   pc_sequencer #(
      .RESET_VECTOR(RV),
      .EXC_VECTOR  (EXV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(intf)
   );

   typedef struct {
      bit          r, st, rdy, br, j, ex, er;
      logic [31:0] bt, jt, epcin;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        flush;
      logic [31:0] epc;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   drv_done = 1'b0;

   // Behavioural model state: a booting flag, an exception-bubble flag and a pending-target queue.
   logic [31:0] m_pc, m_epc;
   bit          m_boot, m_bubble, m_flush, m_mis;
   logic [31:0] m_pend[$];

   function automatic stim_t idle();
      stim_t s;
      s.r = 0; s.st = 0; s.rdy = 1; s.br = 0; s.j = 0; s.ex = 0; s.er = 0;
      s.bt = '0; s.jt = '0; s.epcin = '0;
      return s;
   endfunction

   task automatic model_step(input stim_t s);
      bit          adv;
      logic [31:0] t;
      bit          nf, nm, nb;
      if (s.r) begin
         m_pc = RV; m_epc = '0; m_boot = 1; m_bubble = 0; m_flush = 0; m_mis = 0;
         m_pend.delete();
      end else if (m_boot) begin
         m_boot = 0; m_flush = 0; m_mis = 0;
      end else begin
         adv = !m_bubble && s.rdy && !s.st;
         nf = 0; nm = 0; nb = 0;
         if (s.ex) begin
            m_pc = EXV; m_epc = s.epcin; m_pend.delete(); nf = 1; nb = 1;
         end else if (s.er) begin
            m_pc = m_epc; m_pend.delete(); nf = 1; nb = 1;
         end else if ((s.j || s.br) && m_pend.size() == 0) begin
            t  = s.j ? s.jt : s.bt;
            nm = (t % 4) != 0;
            t  = t - (t % 4);
            nf = 1;
            if (adv) m_pc = t;
            else m_pend.push_back(t);
         end else if (adv) begin
            if (m_pend.size() > 0) m_pc = m_pend.pop_front();
            else m_pc = m_pc + 32'd4;
         end
         m_flush = nf; m_mis = nm; m_bubble = nb;
      end
   endtask

   task automatic drive(input stim_t s);
      exp_t e;
      @(negedge clk);
      rst                = s.r;
      intf.stall         = s.st;
      intf.imem_ready    = s.rdy;
      intf.branch_taken  = s.br;
      intf.branch_target = s.bt;
      intf.jump          = s.j;
      intf.jump_target   = s.jt;
      intf.exc_req       = s.ex;
      intf.exc_pc        = s.epcin;
      intf.eret          = s.er;
      model_step(s);
      e.pc = m_pc; e.fv = !m_boot && !m_bubble; e.flush = m_flush; e.epc = m_epc; e.mis = m_mis;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are presented every cycle, compared 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",          intf.pc,                 e.pc);
            chk("pc_plus4",    intf.pc_plus4,           e.pc + 32'd4);
            chk("fetch_valid", {31'd0, intf.fetch_valid}, {31'd0, e.fv});
            chk("flush",       {31'd0, intf.flush},     {31'd0, e.flush});
            chk("epc",         intf.epc,                e.epc);
            chk("misalign",    {31'd0, intf.misalign},  {31'd0, e.mis});
         end
      end
   end

   initial begin
      stim_t s;
      intf.stall = 0; intf.imem_ready = 1; intf.branch_taken = 0; intf.branch_target = '0;
      intf.jump = 0; intf.jump_target = '0; intf.exc_req = 0; intf.exc_pc = '0; intf.eret = 0;

      // Reset hold, release, free-run to 0x10, 3-cycle stall
      s = idle(); s.r = 1; repeat (3) drive(s);
      s = idle(); repeat (5) drive(s);
      s = idle(); s.st = 1; repeat (3) drive(s);
      s = idle(); repeat (2) drive(s);

      // Branch under back-pressure, second branch ignored while pending
      s = idle(); s.rdy = 0; s.br = 1; s.bt = 32'h100; drive(s);
      s.bt = 32'h200; repeat (2) drive(s);
      s = idle(); repeat (3) drive(s);

      // Exception during stall, then eret+exc together, then lone eret
      s = idle(); s.st = 1; s.ex = 1; s.epcin = 32'h40; drive(s);
      s = idle(); repeat (3) drive(s);
      s = idle(); s.ex = 1; s.er = 1; s.epcin = 32'h88; drive(s);
      s = idle(); repeat (3) drive(s);
      s = idle(); s.er = 1; drive(s);
      s = idle(); repeat (3) drive(s);

      // Misaligned jump, wrap at top of address space
      s = idle(); s.j = 1; s.jt = 32'h1003; s.br = 1; s.bt = 32'h2000; drive(s);
      s = idle(); repeat (2) drive(s);
      s = idle(); s.j = 1; s.jt = 32'hFFFF_FFFC; drive(s);
      s = idle(); repeat (3) drive(s);

      // Reset while a redirect is pending
      s = idle(); s.rdy = 0; s.br = 1; s.bt = 32'h300; drive(s);
      s = idle(); s.rdy = 0; drive(s);
      s = idle(); s.r = 1; s.rdy = 0; drive(s);
      s = idle(); repeat (4) drive(s);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         s       = idle();
         s.r     = ($urandom_range(0, 199) == 0);
         s.st    = ($urandom_range(0, 3) == 0);
         s.rdy   = ($urandom_range(0, 3) != 0);
         s.br    = ($urandom_range(0, 5) == 0);
         s.j     = ($urandom_range(0, 7) == 0);
         s.ex    = ($urandom_range(0, 23) == 0);
         s.er    = ($urandom_range(0, 23) == 0);
         s.bt    = $urandom();
         s.jt    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
         s.epcin = $urandom();
         drive(s);
      end
      s = idle(); drive(s);
      drv_done = 1'b1;
   end

   initial begin
      wait (drv_done);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
